wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin Wishbone arbiter that shares one slave-side bus between up to NUM_MASTERS requesters. Typical requesters are the video sequencing engine, the frame-memory loader and the CPU/debug master. It sits between those masters and the address decoder in front of the LED matrix, frame memory and register slaves. Grants are held for a whole `cyc` and rotate fairly, so a frame-change burst is never split by another master.

## Interface
Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8)
- ADDRESS_WIDTH, 16, Wishbone address width
- DATA_WIDTH, 8, Wishbone data width
- DATA_BYTES, 1, select width
- MAX_HOLD, 64, cycles without ack before forced release (only with WB_ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  master addresses; master k at slice k
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data
- m_we_i  in  NUM_MASTERS  write enables
- m_sel_i  in  NUM_MASTERS*DATA_BYTES  byte selects
- m_stb_i  in  NUM_MASTERS  strobes
- m_cyc_i  in  NUM_MASTERS  cycle requests
- m_cti_i  in  NUM_MASTERS*3  cycle type identifiers
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master acknowledge
- s_adr_o  out  ADDRESS_WIDTH  slave-side address
- s_dat_o  out  DATA_WIDTH  slave-side write data
- s_dat_i  in  DATA_WIDTH  slave-side read data
- s_we_o  out  1  slave-side write enable
- s_sel_o  out  DATA_BYTES  slave-side selects
- s_stb_o  out  1  slave-side strobe
- s_cyc_o  out  1  slave-side cycle
- s_cti_o  out  3  slave-side cycle type
- s_ack_i  in  1  slave acknowledge
- grant_o  out  NUM_MASTERS  one-hot current grant; zero when idle
- busy_o  out  1  high while any grant is held

## Operation
- States: IDLE, GRANT, and BACKOFF (BACKOFF only with the macro).
- IDLE:
  - If any m_cyc_i is high, pick a master by round-robin.
  - The search starts at last_grant+1 (mod NUM_MASTERS) and takes the first master with cyc high.
  - Register the one-hot grant, set last_grant to that index, go to GRANT.
- GRANT:
  - All s_* outputs combinationally mux the granted master's slice.
  - m_ack_o[g] = s_ack_i; all other m_ack_o bits are 0.
  - m_dat_o = s_dat_i unconditionally.
  - When the granted m_cyc_i is low at a clock edge, clear the grant and go to IDLE.
- Outside GRANT: s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o, s_sel_o, s_cti_o = 0; m_ack_o = 0.
- Non-granted masters see no ack and must hold their request. The arbiter never queues or reorders transfers.
- An m_stb_i asserted without m_cyc_i is ignored.
- Reset: state IDLE, grant 0, last_grant = NUM_MASTERS-1 (master 0 wins first), hold counter 0.
  - All outputs 0 during and after reset until the first grant.
  - Reset mid-transfer drops s_cyc_o asynchronously.

## Timing
- Grant latency: m_cyc_i high at edge N gives grant_o and s_cyc_o high after edge N (one cycle).
- Release: s_cyc_o falls combinationally with the granted m_cyc_i.
- Release to next grant: at least one IDLE cycle, so two consecutive grants always have one dead cycle between them.
- Simultaneous requests at the same edge: the nearest index after last_grant wins; the rest are served in rotating order.
- A master re-requesting immediately after release loses to any other pending master.
- No added latency on ack or read data. Both paths are purely combinational through the registered grant.
- busy_o = |grant_o.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A counter of width clog2(MAX_HOLD+1) increments every GRANT cycle with s_stb_o high and s_ack_i low. It clears on s_ack_i and on leaving GRANT.
  - When the counter reaches MAX_HOLD, the grant is cleared and the arbiter enters BACKOFF for one cycle, with s_cyc_o low and no ack.
  - BACKOFF then goes to IDLE. The offending master is not granted again until it drops and re-raises m_cyc_i; a sticky per-master lockout bit clears on its m_cyc_i low.
- WB_ARB_TIMEOUT_EN undefined: no counter, no BACKOFF, no lockout. A grant is held until the master releases cyc; MAX_HOLD is unused.

## Test plan
- Reset release, then m_cyc_i=3'b001 with single-cycle ack: grant_o=001 one cycle after request; s_adr_o equals m_adr_i slice 0; m_ack_o=001 on the ack cycle.
- All three masters request at the same edge, each doing one ack per transfer and dropping cyc: grants occur in order 001, 010, 100, with exactly one idle cycle between each.
- Master 1 holds a 4-beat burst (cti 010/111) while master 0 requests: master 0 is not granted until master 1 drops cyc; no beat of master 1 is split.
- Master 0 releases and re-requests at the next edge while master 2 is pending: master 2 is granted before master 0.
- Assert rst_ni low mid-GRANT: s_cyc_o and grant_o go 0 immediately; after release, the first grant goes to master 0.
- WB_ARB_TIMEOUT_EN with MAX_HOLD=8 and the slave never acking: s_cyc_o drops after 8 stalled cycles; one BACKOFF cycle follows; master 2 is then granted; master 0 stays locked out until it toggles cyc.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter; a grant is held for the master's whole cyc.
// Define WB_ARB_TIMEOUT_EN to add a stall timeout with one-cycle backoff and per-master lockout.
module wb_arbiter #(
  parameter int unsigned NUM_MASTERS   = 3,
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DATA_BYTES    = 1,
  parameter int unsigned MAX_HOLD      = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*DATA_BYTES-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [ADDRESS_WIDTH-1:0]          s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  output logic                              s_we_o,
  output logic [DATA_BYTES-1:0]             s_sel_o,
  output logic                              s_stb_o,
  output logic                              s_cyc_o,
  output logic [2:0]                        s_cti_o,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {StIdle, StGrant, StBackoff} state_e;
`else
  typedef enum logic [0:0] {StIdle, StGrant} state_e;
`endif

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_found;
  logic [IdxW-1:0]        pick_idx;
  logic [IdxW-1:0]        cand;

`ifdef WB_ARB_TIMEOUT_EN
  logic [CntW-1:0]        hold_q, hold_d;
  logic [NUM_MASTERS-1:0] lock_q, lock_d;
  logic                   timeout;

  assign eligible = m_cyc_i & ~lock_q;
  // Fires on the stalled edge that would bring the counter to MAX_HOLD.
  assign timeout  = (state_q == StGrant) && s_stb_o && !s_ack_i &&
                    (hold_q == CntW'(MAX_HOLD - 1));
`else
  assign eligible = m_cyc_i;
`endif

  // Search starts just after the last granted index so the previous owner ranks last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = IdxW'((int'(last_q) + 1 + i) % NUM_MASTERS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
    lock_d  = lock_q & m_cyc_i;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = NUM_MASTERS'(1) << pick_idx;
          last_d  = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!m_cyc_i[last_q]) begin
          grant_d = '0;
          state_d = StIdle;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout) begin
          grant_d        = '0;
          lock_d[last_q] = 1'b1;
          state_d        = StBackoff;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      StBackoff: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  always_comb begin
    hold_d = hold_q;
    if (state_q == StGrant) begin
      if (s_ack_i) begin
        hold_d = '0;
      end else if (s_stb_o) begin
        hold_d = hold_q + 1'b1;
      end
    end
    if (state_d != StGrant) hold_d = '0;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      hold_q  <= '0;
      lock_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      lock_q  <= lock_d;
`endif
    end
  end

  // AND-OR mux on the registered one-hot grant; everything reads zero while no grant is held.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_adr_o = s_adr_o | m_adr_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        s_dat_o = s_dat_o | m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o = s_sel_o | m_sel_i[i*DATA_BYTES +: DATA_BYTES];
        s_cti_o = s_cti_o | m_cti_i[i*3 +: 3];
        s_we_o  = s_we_o  | m_we_i[i];
        s_stb_o = s_stb_o | (m_stb_i[i] & m_cyc_i[i]);
        s_cyc_o = s_cyc_o | m_cyc_i[i];
      end
    end
  end

  assign m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign busy_o  = |grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter (3 masters, 16-bit address, 8-bit data).
// Grant and ack expectations are queued by the stimulus and popped by a negedge monitor.
module tb_wb_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned MaxHold = 8;
`else
  localparam int unsigned MaxHold = 64;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [47:0] m_adr_i;
  logic [23:0] m_dat_i;
  logic [2:0]  m_we_i, m_sel_i, m_stb_i, m_cyc_i;
  logic [8:0]  m_cti_i;
  logic [7:0]  m_dat_o;
  logic [2:0]  m_ack_o;
  logic [15:0] s_adr_o;
  logic [7:0]  s_dat_o;
  logic [7:0]  s_dat_i = 8'h00;
  logic        s_we_o;
  logic [0:0]  s_sel_o;
  logic        s_stb_o, s_cyc_o;
  logic [2:0]  s_cti_o;
  logic        s_ack_i = 1'b0;
  logic [2:0]  grant_o;
  logic        busy_o;

  logic [15:0] adr_a [3];
  logic [7:0]  dat_a [3];
  logic [2:0]  cti_a [3];
  logic        cyc_a [3];
  logic        stb_a [3];
  logic        slave_en = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [2:0] grant; logic [15:0] adr; int gap; } gexp_t;
  typedef struct { logic [2:0] ack; logic [7:0] dat; logic [7:0] wdat; logic [2:0] cti; } aexp_t;
  gexp_t gq[$];
  aexp_t aq[$];

  assign m_adr_i = {adr_a[2], adr_a[1], adr_a[0]};
  assign m_dat_i = {dat_a[2], dat_a[1], dat_a[0]};
  assign m_cti_i = {cti_a[2], cti_a[1], cti_a[0]};
  assign m_cyc_i = {cyc_a[2], cyc_a[1], cyc_a[0]};
  assign m_stb_i = {stb_a[2], stb_a[1], stb_a[0]};
  assign m_we_i  = m_cyc_i;
  assign m_sel_i = 3'b111;

  wb_arbiter #(
    .NUM_MASTERS  (3),
    .ADDRESS_WIDTH(16),
    .DATA_WIDTH   (8),
    .DATA_BYTES   (1),
    .MAX_HOLD     (MaxHold)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i),
    .m_we_i (m_we_i),
    .m_sel_i(m_sel_i),
    .m_stb_i(m_stb_i),
    .m_cyc_i(m_cyc_i),
    .m_cti_i(m_cti_i),
    .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i),
    .s_we_o (s_we_o),
    .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o),
    .s_cti_o(s_cti_o),
    .s_ack_i(s_ack_i),
    .grant_o(grant_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_xfer(input int k, input logic [15:0] adr, input int beats, input int gap);
    gexp_t ge;
    aexp_t ae;
    logic [15:0] a;
    ge.grant = 3'(1 << k);
    ge.adr   = adr;
    ge.gap   = gap;
    gq.push_back(ge);
    for (int b = 0; b < beats; b++) begin
      a       = adr + 16'(b);
      ae.ack  = 3'(1 << k);
      ae.dat  = a[7:0] ^ 8'h5A;
      ae.wdat = 8'h10 + 8'(k);
      ae.cti  = (b == beats - 1) ? 3'b111 : 3'b010;
      aq.push_back(ae);
    end
  endtask

  // Raises cyc after the next edge, runs all beats, then drops cyc after the last ack.
  task automatic master_xfer(input int k, input logic [15:0] adr, input int beats);
    int w;
    @(posedge clk_i); #1;
    cyc_a[k] = 1'b1;
    stb_a[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      adr_a[k] = adr + 16'(b);
      cti_a[k] = (b == beats - 1) ? 3'b111 : 3'b010;
      w = 0;
      do begin
        @(negedge clk_i);
        w++;
      end while (!m_ack_o[k] && w < 200);
      if (!m_ack_o[k]) chk("ack_wait", 32'(m_ack_o[k]), 32'd1);
      @(posedge clk_i); #1;
    end
    cyc_a[k] = 1'b0;
    stb_a[k] = 1'b0;
    cti_a[k] = 3'b000;
  endtask

  // Slave: one-cycle ack on every other cycle of a stalled strobe; data derived from address.
  initial begin
    logic prev;
    forever begin
      @(posedge clk_i);
      prev = s_ack_i;
      #2;
      s_ack_i = slave_en && s_cyc_o && s_stb_o && !prev;
      s_dat_i = s_ack_i ? (s_adr_o[7:0] ^ 8'h5A) : 8'h00;
    end
  end

  // Monitor: pops expectations whenever a new grant or an ack is presented.
  initial begin
    logic [2:0] prev_g;
    int idle_run;
    gexp_t ge;
    aexp_t ae;
    prev_g   = 3'b000;
    idle_run = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_g   = 3'b000;
        idle_run = 0;
      end else begin
        if (grant_o != prev_g && grant_o != 3'b000) begin
          chk("dead_cycle", 32'(prev_g), 32'd0);
          if (gq.size() == 0) begin
            chk("unexpected_grant", 32'(grant_o), 32'd0);
          end else begin
            ge = gq.pop_front();
            chk("grant", 32'(grant_o), 32'(ge.grant));
            chk("s_adr", 32'(s_adr_o), 32'(ge.adr));
            chk("s_cyc_on_grant", 32'(s_cyc_o), 32'd1);
            if (ge.gap >= 0) chk("idle_gap", 32'(idle_run), 32'(ge.gap));
          end
        end
        if (grant_o == 3'b000) idle_run++;
        else idle_run = 0;
        prev_g = grant_o;
        if (m_ack_o != 3'b000) begin
          if (aq.size() == 0) begin
            chk("unexpected_ack", 32'(m_ack_o), 32'd0);
          end else begin
            ae = aq.pop_front();
            chk("m_ack", 32'(m_ack_o), 32'(ae.ack));
            chk("m_dat", 32'(m_dat_o), 32'(ae.dat));
            chk("s_dat", 32'(s_dat_o), 32'(ae.wdat));
            chk("s_cti", 32'(s_cti_o), 32'(ae.cti));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int n;
    logic any;
    for (int i = 0; i < 3; i++) begin
      adr_a[i] = 16'h0000;
      dat_a[i] = 8'h10 + 8'(i);
      cti_a[i] = 3'b000;
      cyc_a[i] = 1'b0;
      stb_a[i] = 1'b0;
    end

    // Reset state, and a strobe without cyc must be ignored
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_m_ack", 32'(m_ack_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni   = 1'b1;
    stb_a[1] = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("stb_no_cyc_grant", 32'(grant_o), 32'd0);
    chk("stb_no_cyc_s_stb", 32'(s_stb_o), 32'd0);
    stb_a[1] = 1'b0;

    // Single master, single-beat: grant one cycle after the request edge
    expect_xfer(0, 16'h1000, 1, -1);
    fork
      master_xfer(0, 16'h1000, 1);
      begin
        @(posedge clk_i);
        @(negedge clk_i);
        chk("latency_before", 32'(grant_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("latency_after", 32'(grant_o), 32'b001);
        chk("busy_after", 32'(busy_o), 32'd1);
      end
    join

    // Three simultaneous requests right after reset: 0, 1, 2 with one idle cycle each
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    expect_xfer(0, 16'h0100, 1, -1);
    expect_xfer(1, 16'h0200, 1, 1);
    expect_xfer(2, 16'h0300, 1, 1);
    fork
      master_xfer(0, 16'h0100, 1);
      master_xfer(1, 16'h0200, 1);
      master_xfer(2, 16'h0300, 1);
    join

    // Master 1 burst is not split by master 0's pending request
    expect_xfer(1, 16'h2000, 4, -1);
    expect_xfer(0, 16'h3000, 1, 1);
    fork
      master_xfer(1, 16'h2000, 4);
      begin
        repeat (2) @(posedge clk_i);
        master_xfer(0, 16'h3000, 1);
      end
    join

    // Master 0 re-requests at the edge after release; pending master 2 goes first
    expect_xfer(0, 16'h4000, 1, -1);
    expect_xfer(2, 16'h5000, 1, 1);
    expect_xfer(0, 16'h4100, 1, 1);
    fork
      begin
        master_xfer(0, 16'h4000, 1);
        master_xfer(0, 16'h4100, 1);
      end
      begin
        repeat (2) @(posedge clk_i);
        master_xfer(2, 16'h5000, 1);
      end
    join

    // Asynchronous reset mid-grant, then master 0 wins first again
    slave_en = 1'b0;
    expect_xfer(1, 16'h6000, 0, -1);
    @(posedge clk_i); #1;
    cyc_a[1] = 1'b1;
    stb_a[1] = 1'b1;
    adr_a[1] = 16'h6000;
    cti_a[1] = 3'b111;
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("midrst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("midrst_grant", 32'(grant_o), 32'd0);
    chk("midrst_s_adr", 32'(s_adr_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    cyc_a[1] = 1'b0;
    stb_a[1] = 1'b0;
    cti_a[1] = 3'b000;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni   = 1'b1;
    slave_en = 1'b1;
    expect_xfer(0, 16'h7000, 1, -1);
    expect_xfer(2, 16'h7200, 1, 1);
    fork
      master_xfer(0, 16'h7000, 1);
      master_xfer(2, 16'h7200, 1);
    join

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: forced release after MAX_HOLD, backoff, then lockout of master 0
    slave_en = 1'b0;
    expect_xfer(0, 16'h8000, 0, -1);
    expect_xfer(2, 16'h8200, 0, 2);
    expect_xfer(0, 16'h8000, 0, -1);
    @(posedge clk_i); #1;
    cyc_a[0] = 1'b1; stb_a[0] = 1'b1; adr_a[0] = 16'h8000; cti_a[0] = 3'b111;
    cyc_a[2] = 1'b1; stb_a[2] = 1'b1; adr_a[2] = 16'h8200; cti_a[2] = 3'b111;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (grant_o == 3'b100) break;
      if (s_cyc_o) n++;
    end
    chk("stall_cycles", 32'(n), 32'd8);
    chk("to_grant2", 32'(grant_o), 32'b100);
    @(posedge clk_i); #1;
    cyc_a[2] = 1'b0; stb_a[2] = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      if (grant_o != 3'b000) any = 1'b1;
    end
    chk("lockout", 32'(any), 32'd0);
    @(posedge clk_i); #1;
    cyc_a[0] = 1'b0;
    @(posedge clk_i); #1;
    cyc_a[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (grant_o == 3'b001) break;
    end
    chk("relock_grant0", 32'(grant_o), 32'b001);
    @(posedge clk_i); #1;
    cyc_a[0] = 1'b0; stb_a[0] = 1'b0;
    slave_en = 1'b1;
`endif

    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("end_idle", 32'(busy_o), 32'd0);
    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("aq_empty", 32'(aq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
